chrono_counter: RTL and testbench
=================================

# chrono_counter

Parametrised, fully synchronous stopwatch/timer core replacing the ripple-clocked centisecond/second/minute/hour chain. A single clock domain with an internal tick prescaler drives a cascaded H:M:S:sub-second counter. The counter can count up (stopwatch) or down (countdown timer), accepts a preset load, and captures lap snapshots. It sits between the debounced button/edge-detect logic and the display formatter.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 100: sub-second resolution; DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- HOUR_MAX, 24: hour modulus, 2..32.
- CS_W, $clog2(TICK_HZ): sub-second field width (derived, not overridable).
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start_stop  in  1  single-cycle pulse; toggles run/stop.
- i_clear  in  1  single-cycle pulse; zero everything, go to STOP.
- i_mode  in  1  0 = count up, 1 = count down; sampled only in STOP.
- i_load  in  1  single-cycle pulse; load preset (STOP only).
- i_pre_h / i_pre_m / i_pre_s / i_pre_ss  in  5/6/6/CS_W  preset fields.
- i_lap  in  1  single-cycle pulse; capture lap snapshot (RUN only).
- o_h / o_m / o_s / o_ss  out  5/6/6/CS_W  live counter.
- o_lap_h / o_lap_m / o_lap_s / o_lap_ss  out  5/6/6/CS_W  last lap snapshot.
- o_lap_valid  out  1  one-cycle pulse when a lap is captured.
- o_running  out  1  high in RUN.
- o_done  out  1  one-cycle pulse when a countdown reaches zero.
- o_wrap  out  1  one-cycle pulse when an up-count wraps to 0.

## Operation
- States: STOP, RUN, DONE. Reset → STOP.
- Input priority per cycle: i_clear > i_load > i_start_stop. i_lap is evaluated independently.
- i_clear, any state: all counters, lap registers and the prescaler → 0; state → STOP.
- i_load, STOP only; ignored in RUN/DONE:
  - Each preset field is clamped to its max legal value: ss TICK_HZ-1, s/m 59, h HOUR_MAX-1.
  - Prescaler → 0.
- i_start_stop:
  - STOP → RUN. Exception: if the latched mode is down and the counter is all zero, stay in STOP.
  - RUN → STOP.
  - DONE → STOP; the counter stays at 0.
- Mode is latched from i_mode on every cycle in STOP. It is frozen in RUN and DONE.
- Prescaler:
  - Counts 0..DIV-1 only in RUN. The internal tick is asserted on the cycle where prescaler == DIV-1.
  - Held in STOP, so pause/resume preserves sub-tick phase.
- Up count on tick:
  - ss increments.
  - Carry ss TICK_HZ-1→0 into s; s 59→0 into m; m 59→0 into h; h HOUR_MAX-1→0.
  - Full rollover (HOUR_MAX-1:59:59:TICK_HZ-1 → 0) pulses o_wrap and keeps running.
- Down count on tick:
  - Borrow mirrors the carry chain: ss 0→TICK_HZ-1 borrows from s, and so on.
  - The tick that produces all-zero moves the state → DONE and pulses o_done.
- Lap: i_lap in RUN copies the current registered counter value, before any same-cycle tick update, into the lap registers and pulses o_lap_valid. Ignored in STOP and DONE.

## Timing
- Reset values: all counters, lap registers, prescaler = 0; o_running, o_done, o_wrap, o_lap_valid = 0; state STOP; latched mode = up.
- All outputs are registered. There is no combinational input→output path.
- i_start_stop sampled at edge N: o_running changes after edge N. The first tick occurs DIV cycles after edge N from prescaler 0.
- Tick on the same cycle as the RUN→STOP start_stop: the counter update is applied and the state goes to STOP.
- Tick on the same cycle as i_clear: clear wins and the counter is 0.
- o_done / o_wrap assert in the cycle after the terminal tick edge, for exactly one cycle.
- rst asserted mid-run: immediate return to reset values, with no pulse outputs.

## Test plan
Parameters for all scenarios: CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset, then start_stop, run 1000 cycles → o_ss=0, o_s=1, o_running=1. Stop, wait 500 cycles, start, run 10 cycles → o_ss=1, with no phase loss.
- Load preset 0:59:59:99 in up mode, run 10 cycles → 1:00:00:00. Load 23:59:59:99, run 10 cycles → 0:00:00:00, o_wrap pulses once.
- Down mode, load 0:00:00:02, start, run 20 cycles → state DONE, counter 0, o_done pulses once. start_stop → STOP. start_stop again → remains STOP.
- Load with fields h=31, m=63, s=60, ss=127 → counter reads 23:59:59:99.
- Lap pulse asserted on a tick cycle at 0:00:00:04 → lap = 0:00:00:04, live = 0:00:00:05, o_lap_valid high 1 cycle. Lap pulse in STOP → no change.
- Clear and start_stop asserted on the same cycle during RUN → all counters and laps 0, state STOP. Async rst mid-run → all outputs 0 immediately.

Source files
------------

// File: rtl/chrono_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : chrono_counter_if
// Purpose  : Control, preset, live-count and lap bundle for chrono_counter.
//            The master side drives the button pulses and presets. The slave
//            side (the counter core) returns the counter and status fields.
// Revision : 1.0 - initial release
// ============================================================================
interface chrono_counter_if #(
    parameter int TICK_HZ = 100
);
    localparam int CS_W = $clog2(TICK_HZ);

    logic            i_start_stop;
    logic            i_clear;
    logic            i_mode;
    logic            i_load;
    logic            i_lap;
    logic [4:0]      i_pre_h;
    logic [5:0]      i_pre_m;
    logic [5:0]      i_pre_s;
    logic [CS_W-1:0] i_pre_ss;

    logic [4:0]      o_h;
    logic [5:0]      o_m;
    logic [5:0]      o_s;
    logic [CS_W-1:0] o_ss;
    logic [4:0]      o_lap_h;
    logic [5:0]      o_lap_m;
    logic [5:0]      o_lap_s;
    logic [CS_W-1:0] o_lap_ss;
    logic            o_lap_valid;
    logic            o_running;
    logic            o_done;
    logic            o_wrap;

    modport master (
        output i_start_stop, i_clear, i_mode, i_load, i_lap,
        output i_pre_h, i_pre_m, i_pre_s, i_pre_ss,
        input  o_h, o_m, o_s, o_ss,
        input  o_lap_h, o_lap_m, o_lap_s, o_lap_ss,
        input  o_lap_valid, o_running, o_done, o_wrap
    );

    modport slave (
        input  i_start_stop, i_clear, i_mode, i_load, i_lap,
        input  i_pre_h, i_pre_m, i_pre_s, i_pre_ss,
        output o_h, o_m, o_s, o_ss,
        output o_lap_h, o_lap_m, o_lap_s, o_lap_ss,
        output o_lap_valid, o_running, o_done, o_wrap
    );
endinterface
`default_nettype wire

// File: rtl/chrono_counter.sv
`default_nettype none
// ============================================================================
// Module   : chrono_counter
// Purpose  : Synchronous stopwatch/countdown core. A prescaler divides clk to
//            a sub-second tick that drives a cascaded H:M:S:SS counter, with
//            preset load, lap capture, wrap and done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module chrono_counter #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MAX = 24
) (
    input wire              clk,
    input wire              rst,
    chrono_counter_if.slave bus
);
    localparam int CS_W = $clog2(TICK_HZ);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CS_W-1:0] c_ss_max    = CS_W'(TICK_HZ - 1);
    localparam logic [5:0]      c_ms_max    = 6'd59;
    localparam logic [4:0]      c_h_max     = 5'(HOUR_MAX - 1);
    localparam logic [PW-1:0]   c_presc_max = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0]      h_q, h_d;
    logic [5:0]      m_q, m_d;
    logic [5:0]      s_q, s_d;
    logic [CS_W-1:0] ss_q, ss_d;
    logic [4:0]      lap_h_q, lap_h_d;
    logic [5:0]      lap_m_q, lap_m_d;
    logic [5:0]      lap_s_q, lap_s_d;
    logic [CS_W-1:0] lap_ss_q, lap_ss_d;
    logic            lap_valid_q, lap_valid_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic            running_q, running_d;

    logic [4:0]      w_up_h, w_dn_h;
    logic [5:0]      w_up_m, w_dn_m;
    logic [5:0]      w_up_s, w_dn_s;
    logic [CS_W-1:0] w_up_ss, w_dn_ss;
    logic            w_tick;
    logic            w_zero;
    logic            w_at_max;
    logic            w_dn_last;
    logic            w_mode_eff;

    assign w_tick    = (state_q == ST_RUN) && (presc_q == c_presc_max);
    assign w_zero    = (h_q == '0) && (m_q == '0) && (s_q == '0) && (ss_q == '0);
    assign w_at_max  = (h_q == c_h_max) && (m_q == c_ms_max) &&
                       (s_q == c_ms_max) && (ss_q == c_ss_max);
    assign w_dn_last = (h_q == '0) && (m_q == '0) && (s_q == '0) &&
                       (ss_q == CS_W'(1));
    // In STOP the mode is transparent so a start decision sees the current selection.
    assign w_mode_eff = (state_q == ST_STOP) ? bus.i_mode : mode_q;

    // Next counter value one tick later, in both directions (carry/borrow chains).
    always_comb begin
        w_up_ss = ss_q + 1'b1;
        w_up_s  = s_q;
        w_up_m  = m_q;
        w_up_h  = h_q;
        if (ss_q == c_ss_max) begin
            w_up_ss = '0;
            if (s_q == c_ms_max) begin
                w_up_s = '0;
                if (m_q == c_ms_max) begin
                    w_up_m = '0;
                    w_up_h = (h_q == c_h_max) ? 5'd0 : h_q + 1'b1;
                end else begin
                    w_up_m = m_q + 1'b1;
                end
            end else begin
                w_up_s = s_q + 1'b1;
            end
        end

        w_dn_ss = ss_q - 1'b1;
        w_dn_s  = s_q;
        w_dn_m  = m_q;
        w_dn_h  = h_q;
        if (ss_q == '0) begin
            w_dn_ss = c_ss_max;
            if (s_q == '0) begin
                w_dn_s = c_ms_max;
                if (m_q == '0) begin
                    w_dn_m = c_ms_max;
                    w_dn_h = (h_q == '0) ? c_h_max : h_q - 1'b1;
                end else begin
                    w_dn_m = m_q - 1'b1;
                end
            end else begin
                w_dn_s = s_q - 1'b1;
            end
        end
    end

    // Next-state, counter, lap and pulse logic with clear > load > start_stop priority.
    always_comb begin
        state_d     = state_q;
        mode_d      = w_mode_eff;
        presc_d     = presc_q;
        h_d         = h_q;
        m_d         = m_q;
        s_d         = s_q;
        ss_d        = ss_q;
        lap_h_d     = lap_h_q;
        lap_m_d     = lap_m_q;
        lap_s_d     = lap_s_q;
        lap_ss_d    = lap_ss_q;
        lap_valid_d = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = w_tick ? '0 : presc_q + 1'b1;
            if (w_tick) begin
                if (mode_q) begin
                    h_d  = w_dn_h;
                    m_d  = w_dn_m;
                    s_d  = w_dn_s;
                    ss_d = w_dn_ss;
                    if (w_dn_last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    h_d  = w_up_h;
                    m_d  = w_up_m;
                    s_d  = w_up_s;
                    ss_d = w_up_ss;
                    wrap_d = w_at_max;
                end
            end
            // Lap takes the value held before this cycle's tick update.
            if (bus.i_lap) begin
                lap_h_d     = h_q;
                lap_m_d     = m_q;
                lap_s_d     = s_q;
                lap_ss_d    = ss_q;
                lap_valid_d = 1'b1;
            end
        end

        if (bus.i_clear) begin
            state_d     = ST_STOP;
            presc_d     = '0;
            h_d         = '0;
            m_d         = '0;
            s_d         = '0;
            ss_d        = '0;
            lap_h_d     = '0;
            lap_m_d     = '0;
            lap_s_d     = '0;
            lap_ss_d    = '0;
            lap_valid_d = 1'b0;
            done_d      = 1'b0;
            wrap_d      = 1'b0;
        end else if (bus.i_load && (state_q == ST_STOP)) begin
            presc_d = '0;
            h_d     = (bus.i_pre_h  > c_h_max)  ? c_h_max  : bus.i_pre_h;
            m_d     = (bus.i_pre_m  > c_ms_max) ? c_ms_max : bus.i_pre_m;
            s_d     = (bus.i_pre_s  > c_ms_max) ? c_ms_max : bus.i_pre_s;
            ss_d    = (bus.i_pre_ss > c_ss_max) ? c_ss_max : bus.i_pre_ss;
        end else if (bus.i_start_stop) begin
            case (state_q)
                ST_STOP: begin
                    // A countdown from zero has nothing to count.
                    if (!(w_mode_eff && w_zero)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:  state_d = ST_STOP;
                ST_DONE: state_d = ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end

        running_d = (state_d == ST_RUN);
    end

    // State and output registers, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STOP;
            mode_q      <= 1'b0;
            presc_q     <= '0;
            h_q         <= '0;
            m_q         <= '0;
            s_q         <= '0;
            ss_q        <= '0;
            lap_h_q     <= '0;
            lap_m_q     <= '0;
            lap_s_q     <= '0;
            lap_ss_q    <= '0;
            lap_valid_q <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            h_q         <= h_d;
            m_q         <= m_d;
            s_q         <= s_d;
            ss_q        <= ss_d;
            lap_h_q     <= lap_h_d;
            lap_m_q     <= lap_m_d;
            lap_s_q     <= lap_s_d;
            lap_ss_q    <= lap_ss_d;
            lap_valid_q <= lap_valid_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
            running_q   <= running_d;
        end
    end

    assign bus.o_h         = h_q;
    assign bus.o_m         = m_q;
    assign bus.o_s         = s_q;
    assign bus.o_ss        = ss_q;
    assign bus.o_lap_h     = lap_h_q;
    assign bus.o_lap_m     = lap_m_q;
    assign bus.o_lap_s     = lap_s_q;
    assign bus.o_lap_ss    = lap_ss_q;
    assign bus.o_lap_valid = lap_valid_q;
    assign bus.o_running   = running_q;
    assign bus.o_done      = done_q;
    assign bus.o_wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_chrono_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_chrono_counter
// Purpose  : Scoreboard bench for chrono_counter at CLK_HZ=1000, TICK_HZ=100
//            (one tick every 10 clocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chrono_counter;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int HOUR_MAX = 24;

    typedef enum int {S_LIVE, S_LAP, S_RUN, S_DONE, S_WRAP, S_LAPV, S_PULSES} sel_e;
    typedef struct {
        sel_e        sel;
        string       tag;
        logic [23:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0, n_wrap = 0, n_lapv = 0;
    int   b_done = 0, b_wrap = 0, b_lapv = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    chrono_counter_if #(.TICK_HZ(TICK_HZ)) bus ();

    chrono_counter #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.o_done)      n_done <= n_done + 1;
        if (bus.o_wrap)      n_wrap <= n_wrap + 1;
        if (bus.o_lap_valid) n_lapv <= n_lapv + 1;
    end

    function automatic logic [23:0] pack(int h, int m, int s, int ss);
        return {5'(h), 6'(m), 6'(s), 7'(ss)};
    endfunction

    function automatic logic [23:0] observe(sel_e sel);
        case (sel)
            S_LIVE:   return {bus.o_h, bus.o_m, bus.o_s, bus.o_ss};
            S_LAP:    return {bus.o_lap_h, bus.o_lap_m, bus.o_lap_s, bus.o_lap_ss};
            S_RUN:    return 24'(bus.o_running);
            S_DONE:   return 24'(n_done - b_done);
            S_WRAP:   return 24'(n_wrap - b_wrap);
            S_LAPV:   return 24'(n_lapv - b_lapv);
            S_PULSES: return 24'({bus.o_done, bus.o_wrap, bus.o_lap_valid});
            default:  return 24'hFFFFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input sel_e sel, input string tag, input logic [23:0] exp);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        b_done = n_done;
        b_wrap = n_wrap;
        b_lapv = n_lapv;
    endtask

    task automatic pulse_ss();
        bus.i_start_stop = 1'b1;
        step(1);
        bus.i_start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.i_clear = 1'b1;
        step(1);
        bus.i_clear = 1'b0;
    endtask

    task automatic pulse_lap();
        bus.i_lap = 1'b1;
        step(1);
        bus.i_lap = 1'b0;
    endtask

    task automatic load(input int h, input int m, input int s, input int ss);
        bus.i_pre_h  = 5'(h);
        bus.i_pre_m  = 6'(m);
        bus.i_pre_s  = 6'(s);
        bus.i_pre_ss = 7'(ss);
        bus.i_load   = 1'b1;
        step(1);
        bus.i_load   = 1'b0;
    endtask

    initial begin
        bus.i_start_stop = 1'b0;
        bus.i_clear      = 1'b0;
        bus.i_mode       = 1'b0;
        bus.i_load       = 1'b0;
        bus.i_lap        = 1'b0;
        bus.i_pre_h      = '0;
        bus.i_pre_m      = '0;
        bus.i_pre_s      = '0;
        bus.i_pre_ss     = '0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset state
        expect_val(S_LIVE,   "rst_live",   pack(0, 0, 0, 0));
        expect_val(S_LAP,    "rst_lap",    pack(0, 0, 0, 0));
        expect_val(S_RUN,    "rst_run",    24'd0);
        expect_val(S_PULSES, "rst_pulses", 24'd0);
        drain();

        // Stopwatch: 1000 cycles = 100 ticks = 1 second
        mark();
        pulse_ss();
        step(1000);
        expect_val(S_LIVE, "sw_1s",  pack(0, 0, 1, 0));
        expect_val(S_RUN,  "sw_run", 24'd1);
        drain();
        pulse_ss();
        step(500);
        expect_val(S_LIVE, "sw_paused",     pack(0, 0, 1, 0));
        expect_val(S_RUN,  "sw_paused_run", 24'd0);
        drain();
        // Prescaler stood at 1 when paused, so the tick arrives 9 cycles after resume.
        pulse_ss();
        step(8);
        expect_val(S_LIVE, "sw_phase_pre", pack(0, 0, 1, 0));
        drain();
        step(1);
        expect_val(S_LIVE, "sw_phase_tick", pack(0, 0, 1, 1));
        drain();
        step(1);
        expect_val(S_LIVE, "sw_resume10", pack(0, 0, 1, 1));
        drain();
        pulse_ss();
        pulse_clr();

        // Up-count carries and full wrap
        load(0, 59, 59, 99);
        mark();
        pulse_ss();
        step(10);
        expect_val(S_LIVE, "carry_hour", pack(1, 0, 0, 0));
        drain();
        pulse_ss();
        load(23, 59, 59, 99);
        mark();
        pulse_ss();
        step(10);
        pulse_ss();
        step(2);
        expect_val(S_LIVE, "wrap_live", pack(0, 0, 0, 0));
        expect_val(S_WRAP, "wrap_once", 24'd1);
        expect_val(S_RUN,  "wrap_stop", 24'd0);
        drain();

        // Countdown to DONE
        pulse_clr();
        bus.i_mode = 1'b1;
        step(1);
        load(0, 0, 0, 2);
        mark();
        pulse_ss();
        step(10);
        expect_val(S_LIVE, "dn_first", pack(0, 0, 0, 1));
        expect_val(S_RUN,  "dn_run",   24'd1);
        drain();
        step(13);
        expect_val(S_LIVE, "dn_zero",      pack(0, 0, 0, 0));
        expect_val(S_RUN,  "dn_done_run",  24'd0);
        expect_val(S_DONE, "dn_done_once", 24'd1);
        drain();
        pulse_ss();
        step(1);
        expect_val(S_RUN, "done_to_stop", 24'd0);
        drain();
        pulse_ss();
        step(1);
        expect_val(S_RUN,  "dn_zero_nostart", 24'd0);
        expect_val(S_LIVE, "dn_zero_hold",    pack(0, 0, 0, 0));
        drain();
        // Load is honoured only in STOP, confirming the state left DONE.
        load(0, 0, 0, 5);
        expect_val(S_LIVE, "stop_load",    pack(0, 0, 0, 5));
        expect_val(S_DONE, "dn_done_once2", 24'd1);
        drain();
        bus.i_mode = 1'b0;
        step(1);

        // Preset clamp
        pulse_clr();
        load(31, 63, 60, 127);
        expect_val(S_LIVE, "clamp", pack(23, 59, 59, 99));
        drain();

        // Lap on a tick cycle: capture 4 while live moves to 5
        pulse_clr();
        mark();
        pulse_ss();
        step(49);
        pulse_lap();
        expect_val(S_LAP,  "lap_value", pack(0, 0, 0, 4));
        expect_val(S_LIVE, "lap_live",  pack(0, 0, 0, 5));
        drain();
        step(2);
        expect_val(S_LAPV, "lap_valid_once", 24'd1);
        drain();
        pulse_ss();
        pulse_lap();
        step(2);
        expect_val(S_LAP,  "lap_stop_hold", pack(0, 0, 0, 4));
        expect_val(S_LAPV, "lap_stop_nopulse", 24'd1);
        expect_val(S_LIVE, "lap_stop_live", pack(0, 0, 0, 5));
        drain();

        // Clear beats start_stop in RUN
        pulse_ss();
        step(25);
        bus.i_clear      = 1'b1;
        bus.i_start_stop = 1'b1;
        step(1);
        bus.i_clear      = 1'b0;
        bus.i_start_stop = 1'b0;
        expect_val(S_LIVE, "clr_live", pack(0, 0, 0, 0));
        expect_val(S_LAP,  "clr_lap",  pack(0, 0, 0, 0));
        expect_val(S_RUN,  "clr_run",  24'd0);
        drain();
        step(15);
        expect_val(S_LIVE, "clr_stays", pack(0, 0, 0, 0));
        drain();

        // Asynchronous reset mid-run
        pulse_ss();
        step(33);
        pulse_lap();
        step(5);
        mark();
        #2 rst = 1'b1;
        #1;
        expect_val(S_LIVE,   "arst_live",   pack(0, 0, 0, 0));
        expect_val(S_LAP,    "arst_lap",    pack(0, 0, 0, 0));
        expect_val(S_RUN,    "arst_run",    24'd0);
        expect_val(S_PULSES, "arst_pulses", 24'd0);
        drain();
        step(3);
        expect_val(S_DONE, "arst_nodone", 24'd0);
        expect_val(S_WRAP, "arst_nowrap", 24'd0);
        expect_val(S_LAPV, "arst_nolapv", 24'd0);
        drain();
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
